// File: rtl/mac_package.sv
`default_nettype none
// ============================================================================
// Module      : mac_package
// Description : Shared types and constants for the MAC engine, its streamers
//               and the job-level controller (mac_fsm).
// Revision    : 1.1 - job descriptor, controller state type, width constants
// ============================================================================
package mac_package;

    // Engine accumulation depth and derived counter width.
    localparam int unsigned MAC_CNT_LEN = 128;
    localparam int unsigned MAC_CNT_W   = $clog2(MAC_CNT_LEN) + 1;

    // Width of the per-job output count.
    localparam int unsigned MAC_ITER_W  = 16;

    // Width of the engine output right-shift amount.
    localparam int unsigned MAC_SHIFT_W = 6;

    // Engine control bundle driven by the controller.
    typedef struct packed {
        logic                   clear;
        logic                   enable;
        logic                   simple_mul;
        logic                   start;
        logic [MAC_SHIFT_W-1:0] shift;
        logic [MAC_CNT_W-1:0]   len;
    } ctrl_engine_t;

    // Engine status bundle returned to the controller.
    typedef struct packed {
        logic [MAC_CNT_W-1:0] cnt;
        logic                 acc_valid;
    } flags_engine_t;

    // Job descriptor handed over by the register file on start.
    typedef struct packed {
        logic [MAC_CNT_W-1:0]   len;
        logic [MAC_ITER_W-1:0]  nb_iter;
        logic [MAC_SHIFT_W-1:0] shift;
        logic                   simple_mul;
    } ctrl_job_t;

    // Job controller states.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_STRM  = 3'd1,
        START      = 3'd2,
        PROD_START = 3'd3,
        PROD_RUN   = 3'd4,
        PROD_CLEAR = 3'd5,
        WAIT_DONE  = 3'd6,
        FINISHED   = 3'd7
    } mac_fsm_state_t;

    // A job produces no traffic when it has no outputs, or when a scalar
    // product is requested over an empty vector.
    function automatic logic job_is_noop(input ctrl_job_t job);
        return (job.nb_iter == '0) || ((job.len == '0) && !job.simple_mul);
    endfunction

endpackage : mac_package
`default_nettype wire

// File: rtl/mac_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mac_fsm
// Description : Job-level controller for the MAC engine. Latches a job,
//               launches the four streamers with computed transfer lengths,
//               sequences engine clear/enable/start per scalar product,
//               counts output handshakes and pulses completion.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_fsm
    import mac_package::*;
#(
    parameter int unsigned CNT_W  = MAC_CNT_W,
    parameter int unsigned ITER_W = MAC_ITER_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  ctrl_job_t                job_i,
    input  logic                     streamers_ready_i,
    input  logic                     d_done_i,
    input  logic                     c_valid_i,
    input  logic                     c_ready_i,
    input  logic                     d_valid_i,
    input  logic                     d_ready_i,
    input  flags_engine_t            flags_engine_i,
    output ctrl_engine_t             ctrl_engine_o,
    output logic                     req_start_o,
    output logic [ITER_W+CNT_W-1:0]  ab_len_o,
    output logic [ITER_W-1:0]        cd_len_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned c_AB_W = ITER_W + CNT_W;

    mac_fsm_state_t    r_state;
    mac_fsm_state_t    w_state_next;
    ctrl_job_t         r_job;
    logic [ITER_W-1:0] r_out_cnt;

    logic              w_c_hs;
    logic              w_d_hs;
    logic [ITER_W-1:0] w_nb_iter;
    logic [ITER_W-1:0] w_cnt_next;
    logic              w_cnt_last;
    logic [c_AB_W-1:0] w_ab_prod;

    logic              w_req_start;
    logic              w_clear;
    logic              w_enable;
    logic              w_start;
    logic              w_done;

    // The engine counter is not needed for sequencing: product boundaries
    // are taken from the observed c/d handshakes instead.
    logic              w_flags_unused;
    assign w_flags_unused = ^flags_engine_i;

    assign w_c_hs     = c_valid_i & c_ready_i;
    assign w_d_hs     = d_valid_i & d_ready_i;
    assign w_nb_iter  = ITER_W'(r_job.nb_iter);
    assign w_cnt_next = r_out_cnt + ITER_W'(1);
    assign w_cnt_last = (w_cnt_next == w_nb_iter);

    // Full-width a/b word count: every output consumes len words of a and b.
    assign w_ab_prod  = c_AB_W'(r_job.nb_iter) * c_AB_W'(r_job.len);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job descriptor is captured only when a start is accepted in IDLE, so
    // lengths and engine configuration stay stable for the whole job.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_job <= '0;
        end else if ((r_state == IDLE) && start_i) begin
            r_job <= job_i;
        end
    end

    // Output handshake counter; only d words accepted in PROD_RUN count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_cnt <= '0;
        end else if (r_state == START) begin
            r_out_cnt <= '0;
        end else if ((r_state == PROD_RUN) && w_d_hs) begin
            r_out_cnt <= w_cnt_next;
        end
    end

    // Next-state logic and state-decoded controls.
    always_comb begin
        w_state_next = r_state;
        w_req_start  = 1'b0;
        w_clear      = 1'b0;
        w_enable     = 1'b0;
        w_start      = 1'b0;
        w_done       = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_next = job_is_noop(job_i) ? FINISHED : WAIT_STRM;
                end
            end

            WAIT_STRM: begin
                if (streamers_ready_i) begin
                    w_state_next = START;
                end
            end

            START: begin
                w_req_start  = 1'b1;
                w_clear      = 1'b1;
                w_state_next = r_job.simple_mul ? PROD_RUN : PROD_START;
            end

            PROD_START: begin
                // Start coincides with the accepted c word so the engine
                // loads its accumulator while its counter is still zero.
                w_enable = 1'b1;
                w_start  = w_c_hs;
                if (w_c_hs) begin
                    w_state_next = PROD_RUN;
                end
            end

            PROD_RUN: begin
                w_enable = 1'b1;
                if (w_d_hs) begin
                    if (!r_job.simple_mul) begin
                        w_state_next = PROD_CLEAR;
                    end else if (w_cnt_last) begin
                        w_state_next = WAIT_DONE;
                    end
                end
            end

            PROD_CLEAR: begin
                // One idle cycle flushes engine counter and accumulator.
                w_clear = 1'b1;
                if (r_out_cnt == w_nb_iter) begin
                    w_state_next = WAIT_DONE;
                end else begin
                    w_state_next = PROD_START;
                end
            end

            WAIT_DONE: begin
                w_enable = 1'b1;
                if (d_done_i) begin
                    w_state_next = FINISHED;
                end
            end

            FINISHED: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Engine control bundle; pulses are masked by reset so they drop in the
    // same cycle reset is raised rather than one cycle later.
    always_comb begin
        ctrl_engine_o            = '0;
        ctrl_engine_o.clear      = w_clear & ~rst_i;
        ctrl_engine_o.enable     = w_enable;
        ctrl_engine_o.start      = w_start & ~rst_i;
        ctrl_engine_o.simple_mul = r_job.simple_mul;
        ctrl_engine_o.shift      = r_job.shift;
        ctrl_engine_o.len        = r_job.len;
    end

    // Streamer launch and transfer lengths.
    always_comb begin
        req_start_o = w_req_start & ~rst_i;
        cd_len_o    = w_nb_iter;
        if (r_job.simple_mul) begin
            ab_len_o = c_AB_W'(r_job.nb_iter);
        end else begin
            ab_len_o = w_ab_prod;
        end
    end

    assign busy_o = (r_state != IDLE);
    assign done_o = w_done;

endmodule : mac_fsm
`default_nettype wire

// File: tb/tb_mac_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_fsm
// Description : Self-checking bench for mac_fsm. Jobs push their expected
//               outcome to a scoreboard; a monitor pops and compares on
//               every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_fsm;
    import mac_package::*;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    ctrl_job_t     job_i = '0;
    logic          streamers_ready_i = 1'b0;
    logic          d_done_i = 1'b0;
    logic          c_valid_i = 1'b0;
    logic          c_ready_i = 1'b0;
    logic          d_valid_i = 1'b0;
    logic          d_ready_i = 1'b0;
    flags_engine_t flags_engine_i = '0;
    ctrl_engine_t  ctrl_engine_o;
    logic          req_start_o;
    logic [MAC_ITER_W+MAC_CNT_W-1:0] ab_len_o;
    logic [MAC_ITER_W-1:0]           cd_len_o;
    logic          busy_o;
    logic          done_o;

    mac_fsm #(
        .CNT_W  (MAC_CNT_W),
        .ITER_W (MAC_ITER_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .job_i             (job_i),
        .streamers_ready_i (streamers_ready_i),
        .d_done_i          (d_done_i),
        .c_valid_i         (c_valid_i),
        .c_ready_i         (c_ready_i),
        .d_valid_i         (d_valid_i),
        .d_ready_i         (d_ready_i),
        .flags_engine_i    (flags_engine_i),
        .ctrl_engine_o     (ctrl_engine_o),
        .req_start_o       (req_start_o),
        .ab_len_o          (ab_len_o),
        .cd_len_o          (cd_len_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] ab;
        logic [31:0] cd;
        int          reqs;
        int          clears;
        int          starts;
        bit          en;
    } exp_t;

    exp_t sb[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_jobs = 0;
    int n_done = 0;

    // Per-job event counters gathered by the monitor.
    int          m_reqs   = 0;
    int          m_clears = 0;
    int          m_starts = 0;
    int          m_ens    = 0;
    logic [31:0] m_ab_req = '0;
    logic [31:0] m_cd_req = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: accumulates per-job activity, scores it on done.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            m_reqs = 0; m_clears = 0; m_starts = 0; m_ens = 0;
            m_ab_req = '0; m_cd_req = '0;
        end else begin
            if (req_start_o) begin
                m_reqs++;
                m_ab_req = 32'(ab_len_o);
                m_cd_req = 32'(cd_len_o);
            end
            if (ctrl_engine_o.clear)  m_clears++;
            if (ctrl_engine_o.start)  m_starts++;
            if (ctrl_engine_o.enable) m_ens++;
            if (done_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    n_done++;
                    chk("sb_reqs",   32'(m_reqs),   32'(e.reqs));
                    chk("sb_clears", 32'(m_clears), 32'(e.clears));
                    chk("sb_starts", 32'(m_starts), 32'(e.starts));
                    chk("sb_enable", 32'(m_ens > 0), 32'(e.en));
                    chk("sb_ab_req", m_ab_req, e.reqs > 0 ? e.ab : 32'd0);
                    chk("sb_cd_req", m_cd_req, e.reqs > 0 ? e.cd : 32'd0);
                    chk("sb_ab_done", 32'(ab_len_o), e.ab);
                    chk("sb_cd_done", 32'(cd_len_o), e.cd);
                end
                m_reqs = 0; m_clears = 0; m_starts = 0; m_ens = 0;
                m_ab_req = '0; m_cd_req = '0;
            end
        end
    end

    function automatic bit model_noop(input int len, input int nb, input bit simple);
        return (nb == 0) || (len == 0 && !simple);
    endfunction

    task automatic push_exp(input int len, input int nb, input bit simple);
        exp_t e;
        bit   noop;
        noop     = model_noop(len, nb, simple);
        e.ab     = simple ? 32'(nb) : 32'(nb * len);
        e.cd     = 32'(nb);
        e.reqs   = noop ? 0 : 1;
        e.clears = noop ? 0 : (simple ? 1 : 1 + nb);
        e.starts = (noop || simple) ? 0 : nb;
        e.en     = !noop;
        sb.push_back(e);
        n_jobs++;
    endtask

    // Start a job and follow it up to the START cycle (or through a no-op).
    task automatic launch(input int len, input int nb, input int sh, input bit simple,
                          input int ready_delay, output bit noop);
        noop = model_noop(len, nb, simple);
        c_valid_i = 1'b0; c_ready_i = 1'b0; d_valid_i = 1'b0; d_ready_i = 1'b0;
        d_done_i  = 1'b0;
        streamers_ready_i = (ready_delay == 0);
        job_i.len        = MAC_CNT_W'(len);
        job_i.nb_iter    = MAC_ITER_W'(nb);
        job_i.shift      = MAC_SHIFT_W'(sh);
        job_i.simple_mul = simple;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        job_i   = '1;
        if (noop) begin
            chk("noop_done", 32'(done_o), 32'd1);
            chk("noop_req",  32'(req_start_o), 32'd0);
            chk("noop_en",   32'(ctrl_engine_o.enable), 32'd0);
            tick();
            chk("noop_done_pulse", 32'(done_o), 32'd0);
            chk("noop_idle", 32'(busy_o), 32'd0);
        end else begin
            chk("launch_busy", 32'(busy_o), 32'd1);
            chk("launch_req_early", 32'(req_start_o), 32'd0);
            for (int i = 0; i < ready_delay; i++) begin
                tick();
                chk("wait_strm_req", 32'(req_start_o), 32'd0);
            end
            streamers_ready_i = 1'b1;
            tick();
            chk("req_latency", 32'(req_start_o), 32'd1);
            chk("start_clear", 32'(ctrl_engine_o.clear), 32'd1);
            chk("start_enable", 32'(ctrl_engine_o.enable), 32'd0);
            chk("eng_len",   32'(ctrl_engine_o.len), 32'(len));
            chk("eng_shift", 32'(ctrl_engine_o.shift), 32'(sh));
            chk("eng_simple", 32'(ctrl_engine_o.simple_mul), 32'(simple));
            streamers_ready_i = 1'b0;
        end
    endtask

    // Free-running streams from the START cycle; c held back for c_delay
    // cycles of PROD_START, d_done raised from cycle dd. Returns cycles to done.
    task automatic wait_done(input int c_delay, input int dd, output int cyc);
        cyc = 0;
        c_ready_i = 1'b1;
        d_valid_i = 1'b1;
        d_ready_i = 1'b1;
        while (1) begin
            c_valid_i = (cyc >= 1 + c_delay);
            d_done_i  = (cyc >= dd);
            @(negedge clk_i);
            if (!c_valid_i) chk("start_hold", 32'(ctrl_engine_o.start), 32'd0);
            tick();
            cyc++;
            if (done_o) break;
            if (cyc > 5000) begin
                chk("timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle_inputs();
        c_valid_i = 1'b0; c_ready_i = 1'b0; d_valid_i = 1'b0; d_ready_i = 1'b0;
        d_done_i  = 1'b0;
    endtask

    task automatic run_job(input int len, input int nb, input int sh, input bit simple,
                           input int c_delay, input int dd, input int ready_delay);
        bit noop;
        int cyc;
        int nat;
        int wd;
        push_exp(len, nb, simple);
        launch(len, nb, sh, simple, ready_delay, noop);
        if (!noop) begin
            nat = simple ? nb + 2 : 3 * nb + 2 + c_delay;
            wd  = nat - 1;
            wait_done(c_delay, dd, cyc);
            chk("job_latency", 32'(cyc), 32'((dd > wd ? dd : wd) + 1));
            idle_inputs();
            tick();
            chk("done_pulse", 32'(done_o), 32'd0);
            chk("back_idle", 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        bit noop;
        int cyc;

        // Reset state
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        chk("rst_ctrl", 32'(ctrl_engine_o), 32'd0);
        chk("rst_req",  32'(req_start_o), 32'd0);
        chk("rst_ab",   32'(ab_len_o), 32'd0);
        chk("rst_cd",   32'(cd_len_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);

        // Scalar job, d_done arrives late
        run_job(4, 3, 0, 1'b0, 0, 20, 0);
        // Simple job
        run_job(9, 5, 3, 1'b1, 0, 0, 0);
        // No-op jobs: zero outputs, and empty scalar vector
        run_job(4, 0, 1, 1'b0, 0, 0, 0);
        run_job(0, 7, 2, 1'b0, 0, 0, 0);
        // Simple job with len 0 is still a real job
        run_job(0, 3, 0, 1'b1, 0, 0, 0);
        // c arrives 7 cycles late, streamers busy for 3 cycles
        run_job(2, 2, 5, 1'b0, 7, 0, 3);

        // d_ready held low in PROD_RUN; start_i re-asserted is ignored
        push_exp(1, 4, 1'b1);
        launch(1, 4, 0, 1'b1, 0, noop);
        d_valid_i = 1'b1;
        d_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start_i = (i == 3 || i == 4);
            job_i   = '0;
            tick();
            chk("stall_busy", 32'(busy_o), 32'd1);
            chk("stall_enable", 32'(ctrl_engine_o.enable), 32'd1);
            chk("stall_done", 32'(done_o), 32'd0);
        end
        start_i = 1'b0;
        wait_done(0, 0, cyc);
        chk("stall_latency", 32'(cyc), 32'd5);
        idle_inputs();
        tick();
        chk("stall_idle", 32'(busy_o), 32'd0);

        // Reset during PROD_RUN aborts the job without done
        push_exp(1, 6, 1'b1);
        launch(1, 6, 4, 1'b1, 0, noop);
        d_valid_i = 1'b1;
        d_ready_i = 1'b0;
        tick();
        d_ready_i = 1'b1;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        void'(sb.pop_back());
        n_jobs--;
        idle_inputs();
        chk("abort_ctrl", 32'(ctrl_engine_o), 32'd0);
        chk("abort_req",  32'(req_start_o), 32'd0);
        chk("abort_ab",   32'(ab_len_o), 32'd0);
        chk("abort_cd",   32'(cd_len_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);

        // Fresh job after abort; a/b length wider than the output count
        run_job(255, 1000, 7, 1'b0, 0, 0, 0);

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("jobs_done", 32'(n_done), 32'(n_jobs));

        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mac_fsm
`default_nettype wire

// File: doc/mac_fsm.md
# mac_fsm

Job-level controller for the MAC engine. It accepts a job configuration (vector length, number of outputs, shift, mode) and starts the four HWPE-Stream streamers with computed transfer lengths. It sequences the engine's clear/enable/start controls for each scalar product, counts output handshakes, and signals completion. It sits between the register file / top-level control and the `mac_engine` datapath plus its streamers.

## Interface
- `CNT_W`, default 8: engine counter width; equals `$clog2(MAC_CNT_LEN)+1`.
- `ITER_W`, default 16: width of the job output count.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset; one clock, synchronous, active-high.
- `start_i`, in, 1: job trigger; sampled only in IDLE.
- `job_i`, in, `ctrl_job_t`: `len` (CNT_W), `nb_iter` (ITER_W), `shift` (6), `simple_mul` (1). Latched on accepted start.
- `streamers_ready_i`, in, 1: all streamers idle and able to accept a request.
- `d_done_i`, in, 1: sink streamer has completed all writes; level or pulse.
- `c_valid_i`, `c_ready_i`, in, 1 each: observed c stream handshake at the engine.
- `d_valid_i`, `d_ready_i`, in, 1 each: observed d stream handshake at the engine.
- `flags_engine_i`, in, `flags_engine_t`: engine counter.
- `ctrl_engine_o`, out, `ctrl_engine_t`: engine `clear`, `enable`, `start`, `simple_mul`, `shift`, `len`.
- `req_start_o`, out, 1: one-cycle pulse that launches all four streamers.
- `ab_len_o`, out, ITER_W+CNT_W: word count for streams a and b.
- `cd_len_o`, out, ITER_W: word count for streams c and d.
- `busy_o`, out, 1: high in every state except IDLE.
- `done_o`, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, WAIT_STRM, START, PROD_START, PROD_RUN, PROD_CLEAR, WAIT_DONE, FINISHED.
- **IDLE**
  - On `start_i`, latch `job_i`.
  - If `nb_iter==0`, or `len==0` with `simple_mul==0`, go to FINISHED (no-op job).
  - Otherwise go to WAIT_STRM.
- **WAIT_STRM**: go to START once `streamers_ready_i` is high.
- **START**
  - `req_start_o=1` and `ctrl_engine_o.clear=1` for exactly this cycle.
  - Next state is PROD_RUN in simple mode, PROD_START in scalar mode.
- **PROD_START** (scalar mode only)
  - `enable=1`.
  - `start = c_valid_i & c_ready_i`; start is pulsed only on the cycle the c word is accepted, so the engine loads the accumulator at `cnt==0`.
  - Go to PROD_RUN on that cycle.
- **PROD_RUN**
  - `enable=1`.
  - Each `d_valid_i & d_ready_i` increments `out_cnt`.
  - Simple mode: when `out_cnt` reaches `nb_iter`, go to WAIT_DONE.
  - Scalar mode: the first d handshake goes to PROD_CLEAR.
- **PROD_CLEAR**
  - `clear=1` and `enable=0` for one cycle; this resets the engine counter and accumulator.
  - If `out_cnt==nb_iter`, go to WAIT_DONE; else go to PROD_START.
- **WAIT_DONE**: `enable=1`; go to FINISHED when `d_done_i` is high.
- **FINISHED**: `done_o=1` for one cycle, then go to IDLE.
- `ctrl_engine_o.len`, `shift` and `simple_mul` always drive the latched job values.
- Lengths, computed from the latched job and stable from START until IDLE:
  - Scalar mode: `ab_len_o = nb_iter*len`, full-width product with no truncation; `cd_len_o = nb_iter`.
  - Simple mode: `ab_len_o = nb_iter` (zero-extended); `cd_len_o = nb_iter`.
- `out_cnt` is ITER_W bits, reset to 0 in START, and never wraps, because `nb_iter` bounds it.

## Timing
- Reset values: all outputs 0, state IDLE, `out_cnt` 0, latched job 0.
- `rst_i` asserted mid-job returns to IDLE on the next edge. No `done_o` is produced, and `req_start_o`, `clear` and `start` drop in the same cycle.
- `start_i` is ignored outside IDLE; there is no queueing.
- Latency, start to `req_start_o`: 2 cycles if `streamers_ready_i` is already high (IDLE → WAIT_STRM → START).
- No-op job: `done_o` is high on the cycle after `start_i`; `req_start_o` never fires.
- Scalar mode costs one extra cycle (PROD_CLEAR) per output. No engine start is issued during PROD_CLEAR.
- Simultaneous d handshake and `out_cnt` reaching `nb_iter`: the state transition takes effect on the same edge as the increment.
- A d handshake seen outside PROD_RUN is not counted.
- Controls are registered-state decodes (Moore), except `start`, which is combinational on the c handshake.

## Structure
- `mac_package` gains:
  - `ctrl_job_t` (packed struct),
  - `mac_fsm_state_t` (enum of the 8 states),
  - the constants `MAC_ITER_W` and `MAC_CNT_W`.
- `ctrl_engine_t` and `flags_engine_t` are reused unchanged.
- No sub-module: FSM, output counter and length multiply are inline.

## Test plan
- Scalar job `len=4, nb_iter=3, shift=0`, streamers ready: `req_start_o` pulses 2 cycles after start, `ab_len_o=12`, `cd_len_o=3`, three PROD_CLEAR pulses, `done_o` once after `d_done_i`.
- Simple job `nb_iter=5`: `ab_len_o=5`, engine never receives `start`, `done_o` follows the fifth d handshake plus `d_done_i`.
- `nb_iter=0`: `done_o` on the cycle after start; no `req_start_o`, no `enable`.
- c arrives 7 cycles late in PROD_START: `start` is held low until the c handshake cycle, then pulses exactly once.
- `d_ready_i` held low for 10 cycles in PROD_RUN: `out_cnt` stalls and the state stays in PROD_RUN; `start_i` re-asserted meanwhile is ignored.
- `rst_i` asserted during PROD_RUN: next cycle all outputs are 0 and `busy_o=0`; a new job then completes normally.
